// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first.
//
// Samples the asynchronous serial line through a 2-flop synchronizer,
// validates the start bit at its midpoint, samples each data bit and the
// stop bit one bit-time apart, and hands each good byte to a one-entry
// holding register.
//
// Handshake (valid/ready):
//   valid is high while the holding register is full. A transfer happens on
//   every rising clk edge where valid & ready are both high. ready is ignored
//   while valid is low. odata is stable from valid rising until the transfer
//   (or until it is replaced by a byte completing in the transfer cycle).
//
// Parameters:
//   freq_hz   system clock frequency in Hz
//   baudrate  line bit rate
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   odata      received byte, meaningful while valid=1
//   valid      holding register full
//   ready      consumer accepts odata when valid & ready
//   busy       high while a frame is in progress (state != IDLE)
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while holding register full
//   dbg_state  current receiver state encoding, for observation only
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int freq_hz  = 100_000_000,
    parameter int baudrate = 115_200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] odata,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int CLKS_PER_BIT = freq_hz / baudrate;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_odata;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    // -----------------------------------------------------------------------
    // Combinational FSM outputs
    // -----------------------------------------------------------------------
    state_t           w_state_next;
    logic             w_sample_data;  // shift r_rx_s into the data register
    logic             w_deliver;      // good stop bit seen this cycle
    logic             w_frame_err;    // bad stop bit seen this cycle

    always_comb begin
        w_state_next  = r_state;
        w_sample_data = 1'b0;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                end
            end

            S_START: begin
                // Re-check the line at mid start bit; a line that has gone
                // high again was a glitch and is dropped silently.
                if (r_baud_cnt == CNT_MID) begin
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (r_baud_cnt == CNT_LAST) begin
                    w_sample_data = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end

            S_STOP: begin
                // Leaving here mid-stop-bit gives half a bit of slack for
                // the next start edge in back-to-back traffic.
                if (r_baud_cnt == CNT_LAST) begin
                    if (r_rx_s) begin
                        w_deliver    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // Hold here until the line returns high so that a line held
                // low yields one frame error rather than a stream of them.
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Input synchronizer (resets to the idle line level)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Baud and bit counters, data shift register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            // Every state change restarts bit timing from zero.
            if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
                r_baud_cnt <= '0;
            end else if (r_baud_cnt == CNT_LAST) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (r_state == S_START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample_data) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // LSB arrives first, so each new bit enters at the top and the
            // first bit ends up in bit 0 after eight shifts.
            if (w_sample_data) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding register, handshake and status pulses
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_odata     <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;

            if (w_deliver) begin
                if (!r_valid || ready) begin
                    // Empty, or the old byte leaves in this same cycle.
                    r_odata <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    // Consumer still holds the previous byte: keep it and
                    // drop the new one.
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign odata     = r_odata;
    assign valid     = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx.
//
// The DUT runs at 17 clocks per bit (HALF_BIT = 8) to keep frames short.
// A frame driven starting right after posedge P0 has its stop bit judged on
// edge P0 + 2 (synchronizer) + 1 (IDLE->START) + 8 (half bit) + 9*17 = 164,
// so valid rises 164 cycles after the start edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int FREQ_HZ = 1_700_000;
    localparam int BAUD    = 100_000;
    localparam int CPB     = 17;

    logic       clk;
    logic       rstn;
    logic       rx;
    logic [7:0] odata;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    logic ready_drv;
    logic ready_tie;
    assign ready = ready_tie ? valid : ready_drv;

    uart_rx #(
        .freq_hz  (FREQ_HZ),
        .baudrate (BAUD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .odata     (odata),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int valid_cyc = 0;
    int busy_cyc  = 0;
    int ferr_cyc  = 0;
    int ovr_cyc   = 0;
    int last_rise = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every accepted byte must be the next expected one.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_byte: got %02h, expected none (t=%0t)", odata, $time);
            end else begin
                check("rx_byte", {24'h0, odata}, {24'h0, exp_q.pop_front()});
            end
        end
        if (valid) valid_cyc++;
        if (busy) busy_cyc++;
        if (frame_err) ferr_cyc++;
        if (overrun) ovr_cyc++;
        if (valid && !prev_valid) last_rise = cyc;
        prev_valid = valid;
    end

    // ---------------- drivers ----------------
    // All drivers start and end at posedge + 1.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int n_data);
        drive_bit(1'b0);
        for (int i = 0; i < n_data; i++) drive_bit(b[i]);
        if (n_data == 8) drive_bit(stop_v);
    endtask

    int v0, b0, e0, o0, start_cyc;

    task automatic snap();
        v0 = valid_cyc;
        b0 = busy_cyc;
        e0 = ferr_cyc;
        o0 = ovr_cyc;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn      = 1'b0;
        rx        = 1'b1;
        ready_drv = 1'b1;
        ready_tie = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_odata", {24'h0, odata}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;
        idle_bits(2);

        // 1) 0x55 with ready=1: one valid cycle, 164 cycles after start edge
        snap();
        exp_q.push_back(8'h55);
        start_cyc = cyc;
        send_frame(8'h55, 1'b1, 8);
        idle_bits(2);
        @(negedge clk);
        check("t1_valid_cycles", valid_cyc - v0, 1);
        check("t1_latency", last_rise - start_cyc, 164);
        check("t1_frame_err", ferr_cyc - e0, 0);
        check("t1_overrun", ovr_cyc - o0, 0);
        check("t1_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;

        // 2) 4-cycle low glitch: busy for exactly HALF_BIT cycles, nothing else
        snap();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle_bits(2);
        @(negedge clk);
        check("t2_busy_cycles", busy_cyc - b0, 8);
        check("t2_valid_cycles", valid_cyc - v0, 0);
        check("t2_frame_err", ferr_cyc - e0, 0);
        check("t2_busy_now", {31'h0, busy}, 0);
        @(posedge clk); #1;

        // 3) 0xA3 with bad stop, line low 3 more bits, then good 0x3C
        snap();
        send_frame(8'hA3, 1'b0, 8);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        idle_bits(2);
        @(negedge clk);
        check("t3_frame_err_pulses", ferr_cyc - e0, 1);
        check("t3_valid_after_err", valid_cyc - v0, 0);
        @(posedge clk); #1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 8);
        idle_bits(2);
        @(negedge clk);
        check("t3_valid_cycles", valid_cyc - v0, 1);
        check("t3_overrun", ovr_cyc - o0, 0);
        check("t3_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;

        // 4) ready=0, 0x11 then 0x22 back-to-back: 0x22 overruns
        snap();
        ready_drv = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 8);
        send_frame(8'h22, 1'b1, 8);
        idle_bits(1);
        @(negedge clk);
        check("t4_valid_held", {31'h0, valid}, 1);
        check("t4_odata_held", {24'h0, odata}, 32'h11);
        check("t4_overrun_pulses", ovr_cyc - o0, 1);
        check("t4_frame_err", ferr_cyc - e0, 0);
        @(posedge clk); #1;
        ready_drv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_dropped", {31'h0, valid}, 0);
        check("t4_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;

        // 5) ready tied to valid: 0x00, 0xFF, 0x81 back-to-back
        snap();
        ready_tie = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        send_frame(8'h81, 1'b1, 8);
        idle_bits(2);
        @(negedge clk);
        check("t5_valid_cycles", valid_cyc - v0, 3);
        check("t5_frame_err", ferr_cyc - e0, 0);
        check("t5_overrun", ovr_cyc - o0, 0);
        check("t5_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        ready_tie = 1'b0;

        // 6) reset mid-DATA of 0x5A, then clean 0xC3. Load a nonzero byte
        //    first (ready=0) so the reset clearing odata is visible.
        ready_drv = 1'b0;
        send_frame(8'h99, 1'b1, 8);
        idle_bits(1);
        @(negedge clk);
        check("t6_preload", {24'h0, odata}, 32'h99);
        @(posedge clk); #1;
        send_frame(8'h5A, 1'b1, 4);
        rstn = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        check("t6_rst_odata", {24'h0, odata}, 32'h0);
        check("t6_rst_valid", {31'h0, valid}, 0);
        check("t6_rst_busy", {31'h0, busy}, 0);
        check("t6_rst_frame_err", {31'h0, frame_err}, 0);
        check("t6_rst_overrun", {31'h0, overrun}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn      = 1'b1;
        ready_drv = 1'b1;
        idle_bits(3);
        snap();
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 8);
        idle_bits(2);
        @(negedge clk);
        check("t6_valid_cycles", valid_cyc - v0, 1);
        check("t6_frame_err", ferr_cyc - e0, 0);
        check("t6_overrun", ovr_cyc - o0, 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #2_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: simulation did not complete, got time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
